// File: rtl/i2c_apb_sequencer_if.sv
// rtl/i2c_apb_sequencer_if.sv - APB bus between the I2C sequencer and the I2C register block
interface i2c_apb_sequencer_if;
  logic       psel_o;
  logic       penable_o;
  logic       pwrite_o;
  logic [7:0] paddr_o;
  logic [7:0] pwdata_o;
  logic [7:0] prdata_i;
  logic       pready_i;

  modport master (
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    input  prdata_i, pready_i
  );

  modport slave (
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    output prdata_i, pready_i
  );
endinterface

// File: rtl/i2c_apb_sequencer.sv
// rtl/i2c_apb_sequencer.sv - APB master running one full I2C transfer on the register block per request
module i2c_apb_sequencer #(
  parameter int POLL_LIMIT = 1024,
  parameter int MAX_LEN    = 8
) (
  input  logic                      pclk_i,
  input  logic                      preset_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_rw_i,
  input  logic [6:0]                req_addr_i,
  input  logic [3:0]                req_len_i,
  input  logic [7:0]                req_prescaler_i,
  input  logic [7:0]                tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [7:0]                rx_data_o,
  output logic                      rx_valid_o,
  output logic                      done_o,
  output logic                      error_o,
  i2c_apb_sequencer_if.master       apb
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_LIMIT);

  localparam logic [7:0] A_PRESCALER = 8'h00;
  localparam logic [7:0] A_CMD       = 8'h01;
  localparam logic [7:0] A_TRANSMIT  = 8'h02;
  localparam logic [7:0] A_RECEIVE   = 8'h03;
  localparam logic [7:0] A_ADDR_RW   = 8'h04;
  localparam logic [7:0] A_STATUS    = 8'h05;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_PRE, S_CFG_ADDR, S_LOAD_TX, S_START,
    S_POLL, S_READ_RX, S_CLEAR, S_DONE
  } state_e;

  typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_GAP} phase_e;

  state_e         state_q, state_d;
  phase_e         phase_q, phase_d;
  logic           rw_q, rw_d;
  logic [6:0]     addr_q, addr_d;
  logic [3:0]     len_q, len_d;
  logic [7:0]     pre_q, pre_d;
  logic [3:0]     byte_q, byte_d;
  logic [3:0]     rx_cnt_q, rx_cnt_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic           err_q, err_d;
  logic [7:0]     txb_q, txb_d;

  logic           psel_c, penable_c, pwrite_c;
  logic [7:0]     paddr_c, pwdata_c;
  logic [7:0]     acc_addr, acc_wdata;
  logic           acc_write, acc_active;
  logic [PCW-1:0] poll_inc;

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_SETUP;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      pre_q    <= '0;
      byte_q   <= '0;
      rx_cnt_q <= '0;
      poll_q   <= '0;
      err_q    <= 1'b0;
      txb_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      pre_q    <= pre_d;
      byte_q   <= byte_d;
      rx_cnt_q <= rx_cnt_d;
      poll_q   <= poll_d;
      err_q    <= err_d;
      txb_q    <= txb_d;
    end
  end

  // Per-state access description; every non-idle, non-done state is exactly one APB access.
  always_comb begin
    acc_active = 1'b1;
    acc_write  = 1'b1;
    acc_addr   = A_CMD;
    acc_wdata  = 8'h00;
    case (state_q)
      S_CFG_PRE:  begin acc_addr = A_PRESCALER; acc_wdata = pre_q; end
      S_CFG_ADDR: begin acc_addr = A_ADDR_RW;   acc_wdata = {addr_q, rw_q}; end
      S_LOAD_TX:  begin
        acc_addr  = A_TRANSMIT;
        acc_wdata = (phase_q == PH_SETUP) ? tx_data_i : txb_q;
      end
      S_START:    begin acc_addr = A_CMD; acc_wdata = 8'h01; end
      S_POLL:     begin acc_addr = A_STATUS;  acc_write = 1'b0; end
      S_READ_RX:  begin acc_addr = A_RECEIVE; acc_write = 1'b0; end
      S_CLEAR:    begin acc_addr = A_CMD; acc_wdata = 8'h00; end
      default:    acc_active = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    len_d       = len_q;
    pre_d       = pre_q;
    byte_d      = byte_q;
    rx_cnt_d    = rx_cnt_q;
    poll_d      = poll_q;
    err_d       = err_q;
    txb_d       = txb_q;
    psel_c      = 1'b0;
    penable_c   = 1'b0;
    pwrite_c    = 1'b0;
    paddr_c     = 8'h00;
    pwdata_c    = 8'h00;
    req_ready_o = 1'b0;
    tx_ready_o  = 1'b0;
    rx_valid_o  = 1'b0;
    rx_data_o   = 8'h00;
    done_o      = 1'b0;
    error_o     = 1'b0;
    poll_inc    = (poll_q == POLL_MAX) ? poll_q : poll_q + 1'b1;

    if (state_q == S_IDLE) begin
      req_ready_o = 1'b1;
      if (req_valid_i) begin
        rw_d     = req_rw_i;
        addr_d   = req_addr_i;
        len_d    = req_len_i;
        pre_d    = req_prescaler_i;
        byte_d   = '0;
        rx_cnt_d = '0;
        poll_d   = '0;
        phase_d  = PH_SETUP;
        if (req_len_i == 4'd0 || int'(req_len_i) > MAX_LEN) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d   = 1'b0;
          state_d = S_CFG_PRE;
        end
      end
    end else if (state_q == S_DONE) begin
      done_o  = 1'b1;
      error_o = err_q;
      state_d = S_IDLE;
    end else if (acc_active) begin
      case (phase_q)
        PH_SETUP: begin
          // A transmit byte is only presented once the source has one; the bus idles until then.
          if (state_q != S_LOAD_TX || tx_valid_i) begin
            psel_c  = 1'b1;
            phase_d = PH_ACCESS;
            if (state_q == S_LOAD_TX) begin
              tx_ready_o = 1'b1;
              txb_d      = tx_data_i;
            end
          end
        end
        PH_ACCESS: begin
          psel_c    = 1'b1;
          penable_c = 1'b1;
          if (apb.pready_i) phase_d = PH_GAP;
        end
        default: begin
          phase_d = PH_SETUP;
          case (state_q)
            S_CFG_PRE:  state_d = S_CFG_ADDR;
            S_CFG_ADDR: state_d = rw_q ? S_START : S_LOAD_TX;
            S_LOAD_TX: begin
              byte_d = byte_q + 4'd1;
              if (byte_q + 4'd1 == len_q) state_d = S_START;
            end
            S_START:    state_d = S_POLL;
            S_POLL: begin
              poll_d = poll_inc;
              if (apb.prdata_i[3]) begin
                err_d   = 1'b1;
                state_d = S_CLEAR;
              end else if (rw_q && apb.prdata_i[1] && rx_cnt_q < len_q) begin
                state_d = S_READ_RX;
              end else if (!apb.prdata_i[0] && (!rw_q || rx_cnt_q == len_q)) begin
                state_d = S_CLEAR;
              end else if (poll_inc == POLL_MAX) begin
                err_d   = 1'b1;
                state_d = S_CLEAR;
              end
            end
            S_READ_RX: begin
              rx_valid_o = 1'b1;
              rx_data_o  = apb.prdata_i;
              if (rx_cnt_q < len_q) rx_cnt_d = rx_cnt_q + 4'd1;
              state_d = S_POLL;
            end
            default:    state_d = S_DONE;
          endcase
        end
      endcase
      if (psel_c) begin
        paddr_c  = acc_addr;
        pwrite_c = acc_write;
        pwdata_c = acc_write ? acc_wdata : 8'h00;
      end
    end
  end

  assign apb.psel_o    = psel_c;
  assign apb.penable_o = penable_c;
  assign apb.pwrite_o  = pwrite_c;
  assign apb.paddr_o   = paddr_c;
  assign apb.pwdata_o  = pwdata_c;

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// tb/tb_i2c_apb_sequencer.sv - directed self-checking bench for i2c_apb_sequencer
module tb_i2c_apb_sequencer;

  logic       pclk_i = 1'b0;
  logic       preset_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic       req_rw_i = 1'b0;
  logic [6:0] req_addr_i = '0;
  logic [3:0] req_len_i = '0;
  logic [7:0] req_prescaler_i = '0;
  logic [7:0] tx_data_i = '0;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       done_o;
  logic       error_o;

  i2c_apb_sequencer_if apb ();

  i2c_apb_sequencer #(.POLL_LIMIT(4), .MAX_LEN(8)) dut (
    .pclk_i          (pclk_i),
    .preset_i        (preset_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_rw_i        (req_rw_i),
    .req_addr_i      (req_addr_i),
    .req_len_i       (req_len_i),
    .req_prescaler_i (req_prescaler_i),
    .tx_data_i       (tx_data_i),
    .tx_valid_i      (tx_valid_i),
    .tx_ready_o      (tx_ready_o),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .apb             (apb.master)
  );

  always #5 pclk_i = ~pclk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model state and scoreboards; entries are {write, addr, data}.
  logic [16:0] log_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  rxlog_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  st_q[$];
  logic [7:0]  rxd_q[$];
  logic [7:0]  txq[$];
  logic [7:0]  def_status = 8'h00;
  int          stall_n = 0;
  int          stall_cnt = 0;
  logic        tx_en = 1'b0;
  int          done_cnt = 0;
  logic        err_seen = 1'b0;
  logic [16:0] snap = '0;
  logic        prev_psel = 1'b0;

  initial begin
    apb.prdata_i = 8'h00;
    apb.pready_i = 1'b0;
  end

  always begin : slave_mon
    logic        fire;
    logic        fw;
    logic [7:0]  fa;
    logic [7:0]  fd;
    logic        tx_pop;
    @(negedge pclk_i);
    fire = 1'b0; fw = 1'b0; fa = '0; fd = '0; tx_pop = 1'b0;
    if (!preset_i) begin
      if (apb.psel_o && !apb.penable_o) begin
        check_eq("gap_before_setup", {31'd0, prev_psel}, 32'd0);
        snap = {apb.pwrite_o, apb.paddr_o, apb.pwdata_o};
      end
      if (apb.psel_o && apb.penable_o) begin
        check_eq("access_stable", {15'd0, apb.pwrite_o, apb.paddr_o, apb.pwdata_o}, {15'd0, snap});
        apb.pready_i = (stall_cnt >= stall_n);
        stall_cnt++;
        fire = apb.pready_i;
        fw = apb.pwrite_o; fa = apb.paddr_o; fd = apb.pwdata_o;
      end else begin
        apb.pready_i = 1'b0;
        stall_cnt = 0;
      end
      if (rx_valid_o) rxlog_q.push_back(rx_data_o);
      if (done_o) begin done_cnt++; err_seen = error_o; end
      if (tx_ready_o) tx_pop = 1'b1;
    end
    prev_psel = apb.psel_o;
    @(posedge pclk_i);
    #1;
    if (fire) begin
      if (!fw) begin
        if (fa == 8'h05) fd = (st_q.size() != 0) ? st_q.pop_front() : def_status;
        else if (fa == 8'h03) fd = (rxd_q.size() != 0) ? rxd_q.pop_front() : 8'h00;
        else fd = 8'h00;
        apb.prdata_i = fd;
      end
      log_q.push_back({fw, fa, fd});
    end
    if (tx_pop && txq.size() != 0) void'(txq.pop_front());
    tx_valid_i = tx_en && (txq.size() != 0);
    tx_data_i  = (txq.size() != 0) ? txq[0] : 8'h00;
  end

  task automatic setup(input int stall, input logic [7:0] dstat);
    stall_n = stall;
    def_status = dstat;
    log_q.delete(); exp_q.delete(); rxlog_q.delete(); exp_rx_q.delete();
    st_q.delete(); rxd_q.delete(); txq.delete();
    tx_en = 1'b1;
  endtask

  task automatic ex(input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({w, a, d});
  endtask

  task automatic start_req(input logic rw, input logic [6:0] a, input logic [3:0] len, input logic [7:0] pre);
    @(posedge pclk_i); #1;
    req_rw_i = rw; req_addr_i = a; req_len_i = len; req_prescaler_i = pre;
    req_valid_i = 1'b1;
    @(posedge pclk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err, output int cyc);
    int base;
    base = done_cnt;
    cyc = 0;
    while (done_cnt == base && cyc < 3000) begin
      @(negedge pclk_i);
      cyc++;
    end
    check_eq({tag, "_done"}, done_cnt - base, 1);
    check_eq({tag, "_err"}, {31'd0, err_seen}, {31'd0, exp_err});
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_apb_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) check_eq($sformatf("%s_apb%0d", tag, i), {15'd0, log_q[i]}, {15'd0, exp_q[i]});
    check_eq({tag, "_rx_count"}, rxlog_q.size(), exp_rx_q.size());
    for (int i = 0; i < exp_rx_q.size(); i++)
      if (i < rxlog_q.size()) check_eq($sformatf("%s_rx%0d", tag, i), {24'd0, rxlog_q[i]}, {24'd0, exp_rx_q[i]});
  endtask

  task automatic exp_write_pre(input logic [7:0] pre, input logic [7:0] adr, input logic [7:0] b0, input logic [7:0] b1, input int nb);
    ex(1, 8'h00, pre); ex(1, 8'h04, adr); ex(1, 8'h02, b0);
    if (nb > 1) ex(1, 8'h02, b1);
    ex(1, 8'h01, 8'h01);
  endtask

  initial begin
    int cyc;
    int base;
    repeat (3) @(posedge pclk_i);
    #1 preset_i = 1'b0;
    @(negedge pclk_i);
    check_eq("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    check_eq("rst_psel", {31'd0, apb.psel_o}, 32'd0);
    check_eq("rst_outs", {27'd0, done_o, error_o, tx_ready_o, rx_valid_o, apb.penable_o}, 32'd0);

    // Write of two bytes with two busy polls.
    setup(0, 8'h00);
    txq = '{8'hA5, 8'h3C}; st_q = '{8'h01, 8'h01, 8'h00};
    start_req(1'b0, 7'h50, 4'd2, 8'h10);
    wait_done("wr2", 1'b0, cyc);
    exp_write_pre(8'h10, 8'hA0, 8'hA5, 8'h3C, 2);
    ex(0, 8'h05, 8'h01); ex(0, 8'h05, 8'h01); ex(0, 8'h05, 8'h00); ex(1, 8'h01, 8'h00);
    check_log("wr2");

    // Read of three bytes.
    setup(0, 8'h00);
    st_q = '{8'h03, 8'h03, 8'h03, 8'h00}; rxd_q = '{8'h11, 8'h22, 8'h33};
    start_req(1'b1, 7'h21, 4'd3, 8'h04);
    wait_done("rd3", 1'b0, cyc);
    ex(1, 8'h00, 8'h04); ex(1, 8'h04, 8'h43); ex(1, 8'h01, 8'h01);
    ex(0, 8'h05, 8'h03); ex(0, 8'h03, 8'h11); ex(0, 8'h05, 8'h03); ex(0, 8'h03, 8'h22);
    ex(0, 8'h05, 8'h03); ex(0, 8'h03, 8'h33); ex(0, 8'h05, 8'h00); ex(1, 8'h01, 8'h00);
    exp_rx_q = '{8'h11, 8'h22, 8'h33};
    check_log("rd3");

    // Same write with five wait states on every access.
    setup(5, 8'h00);
    txq = '{8'hA5, 8'h3C}; st_q = '{8'h01, 8'h01, 8'h00};
    start_req(1'b0, 7'h50, 4'd2, 8'h10);
    wait_done("stall", 1'b0, cyc);
    exp_write_pre(8'h10, 8'hA0, 8'hA5, 8'h3C, 2);
    ex(0, 8'h05, 8'h01); ex(0, 8'h05, 8'h01); ex(0, 8'h05, 8'h00); ex(1, 8'h01, 8'h00);
    check_log("stall");

    // Busy forever: timeout after exactly POLL_LIMIT status reads.
    setup(0, 8'h01);
    txq = '{8'h77};
    start_req(1'b0, 7'h50, 4'd1, 8'h10);
    wait_done("tmo", 1'b1, cyc);
    exp_write_pre(8'h10, 8'hA0, 8'h77, 8'h00, 1);
    for (int i = 0; i < 4; i++) ex(0, 8'h05, 8'h01);
    ex(1, 8'h01, 8'h00);
    check_log("tmo");

    // Ack error on the first poll.
    setup(0, 8'h01);
    txq = '{8'h5A}; st_q = '{8'h09};
    start_req(1'b0, 7'h50, 4'd1, 8'h10);
    wait_done("ackerr", 1'b1, cyc);
    exp_write_pre(8'h10, 8'hA0, 8'h5A, 8'h00, 1);
    ex(0, 8'h05, 8'h09); ex(1, 8'h01, 8'h00);
    check_log("ackerr");

    // Bad lengths: zero and above MAX_LEN.
    setup(0, 8'h00);
    start_req(1'b0, 7'h50, 4'd0, 8'h10);
    wait_done("len0", 1'b1, cyc);
    check_eq("len0_latency_ok", {31'd0, cyc <= 2}, 32'd1);
    check_log("len0");
    setup(0, 8'h00);
    start_req(1'b1, 7'h50, 4'd9, 8'h10);
    wait_done("len9", 1'b1, cyc);
    check_log("len9");

    // Transmit byte withheld: no bus activity until it shows up.
    setup(0, 8'h00);
    tx_en = 1'b0;
    txq = '{8'hC3}; st_q = '{8'h00};
    start_req(1'b0, 7'h12, 4'd1, 8'h02);
    cyc = 0;
    while (log_q.size() < 2 && cyc < 200) begin @(negedge pclk_i); cyc++; end
    check_eq("txw_cfg_reached", {31'd0, log_q.size() >= 2}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk_i);
      check_eq("txw_psel_idle", {31'd0, apb.psel_o}, 32'd0);
    end
    check_eq("txw_busy_not_ready", {31'd0, req_ready_o}, 32'd0);
    @(posedge pclk_i); #2;
    tx_en = 1'b1;
    wait_done("txw", 1'b0, cyc);
    exp_write_pre(8'h02, 8'h24, 8'hC3, 8'h00, 1);
    ex(0, 8'h05, 8'h00); ex(1, 8'h01, 8'h00);
    check_log("txw");

    // Reset while a status read is stalled in ACCESS.
    setup(20, 8'h01);
    txq = '{8'h99};
    start_req(1'b0, 7'h50, 4'd1, 8'h10);
    cyc = 0;
    while (!(apb.psel_o && apb.penable_o && apb.paddr_o == 8'h05) && cyc < 3000) begin
      @(negedge pclk_i); cyc++;
    end
    check_eq("rst_poll_reached", {31'd0, apb.paddr_o == 8'h05}, 32'd1);
    base = done_cnt;
    preset_i = 1'b1;
    @(posedge pclk_i); #1;
    preset_i = 1'b0;
    @(negedge pclk_i);
    check_eq("midrst_psel", {31'd0, apb.psel_o}, 32'd0);
    check_eq("midrst_ready", {31'd0, req_ready_o}, 32'd1);
    repeat (3) @(negedge pclk_i);
    check_eq("midrst_no_done", done_cnt - base, 0);

    setup(0, 8'h00);
    txq = '{8'hA5, 8'h3C}; st_q = '{8'h00};
    start_req(1'b0, 7'h50, 4'd2, 8'h10);
    wait_done("post_rst", 1'b0, cyc);
    exp_write_pre(8'h10, 8'hA0, 8'hA5, 8'h3C, 2);
    ex(0, 8'h05, 8'h00); ex(1, 8'h01, 8'h00);
    check_log("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
